// File: rtl/onehot_key_encoder.sv
// Synchronises, debounces and priority-encodes four active-low key lines.
// Emits one 2-bit code per press over a valid/ready handshake.
module onehot_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din_n,
  output logic [1:0] code,
  output logic       valid,
  input  logic       ready,
  output logic       key_down,
  output logic       multi,
  output logic       overrun
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  localparam logic [3:0]       ALL_OFF  = 4'b1111;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  function automatic logic [1:0] encode_low_zero(input logic [3:0] v);
    logic [1:0] r;
    casez (v)
      4'b???0: r = 2'd0;
      4'b??01: r = 2'd1;
      4'b?011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Clearing the lowest set bit of the asserted mask leaves a residue only when two or more are set.
  function automatic logic many_zeros(input logic [3:0] v);
    logic [3:0] z;
    z = ~v;
    return (z & (z - 4'd1)) != 4'd0;
  endfunction

  logic [3:0]       s1_q, s2_q, s2_prev_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next_s;
  state_t           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d, overrun_q, overrun_d, press_s;

  // Debounce counter and stable-level update.
  always_comb begin
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    cnt_next_s = {CNT_W{1'b0}};
    if (s2_q == stable_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      if (s2_q != s2_prev_q) begin
        cnt_next_s = CNT_ONE;
      end else if (cnt_q == CNT_MAX) begin
        cnt_next_s = cnt_q;
      end else begin
        cnt_next_s = cnt_q + CNT_ONE;
      end
      if (cnt_next_s >= CNT_DONE) begin
        stable_d = s2_q;
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_next_s;
      end
    end
  end

  // Press detection, state transitions and output-register next values.
  always_comb begin
    state_d   = state_q;
    press_s   = 1'b0;
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stable_q != ALL_OFF) begin
          state_d = ST_HELD;
          press_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (stable_q == ALL_OFF) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A press that finds the previous code still unconsumed is dropped, not queued.
    if (press_s && (!valid_q || ready)) begin
      code_d  = encode_low_zero(stable_q);
      valid_d = 1'b1;
    end else if (press_s) begin
      overrun_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= ALL_OFF;
      s2_q      <= ALL_OFF;
      s2_prev_q <= ALL_OFF;
      stable_q  <= ALL_OFF;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      s1_q      <= din_n;
      s2_q      <= s1_q;
      s2_prev_q <= s2_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
    end
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      code_q    <= 2'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;
  assign key_down = (stable_q != ALL_OFF);
  assign multi    = many_zeros(stable_q);

endmodule

// File: tb/tb_onehot_key_encoder.sv
// Self-checking bench: directed scenarios plus random key/ready traffic,
// compared every cycle against a run-length behavioural model.
module tb_onehot_key_encoder;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din_n;
  logic       ready;
  logic [1:0] code;
  logic       valid, key_down, multi, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;
  int ovr_cnt = 0;
  logic pv = 1'b0;

  // model state
  logic [3:0] m_s1, m_s2, m_stable, m_stable_last, m_run_val;
  int         m_run_len;
  logic [1:0] m_code;
  logic       m_valid, m_ovr;

  onehot_key_encoder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .din_n(din_n), .code(code), .valid(valid),
    .ready(ready), .key_down(key_down), .multi(multi), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_enc(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i] == 1'b0) r = 2'(i);
    return r;
  endfunction

  function automatic logic m_multi(input logic [3:0] v);
    int z = 0;
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) z++;
    return z > 1;
  endfunction

  task automatic m_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF; m_stable_last = 4'hF;
    m_run_val = 4'hF; m_run_len = 0;
    m_code = 2'd0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  // One clock edge: a level becomes stable once the synchronised input has shown it for DB edges in a row.
  task automatic m_step();
    logic [3:0] s2v;
    logic ev;
    s2v = m_s2;
    m_s2 = m_s1;
    m_s1 = din_n;
    if (s2v == m_run_val) begin
      if (m_run_len < 100000) m_run_len++;
    end else begin
      m_run_val = s2v;
      m_run_len = 1;
    end
    ev = (m_stable != 4'hF) && (m_stable_last == 4'hF);
    m_ovr = 1'b0;
    if (ev) begin
      if (!m_valid || ready) begin
        m_code  = m_enc(m_stable);
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    m_stable_last = m_stable;
    if (s2v != m_stable && m_run_len >= DB) m_stable = s2v;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("code", 8'(code), 8'(m_code));
      chk("valid", 8'(valid), 8'(m_valid));
      chk("overrun", 8'(overrun), 8'(m_ovr));
      chk("key_down", 8'(key_down), 8'(m_stable != 4'hF));
      chk("multi", 8'(multi), 8'(m_multi(m_stable)));
      if (valid === 1'b1 && pv !== 1'b1) rises++;
      if (overrun === 1'b1) ovr_cnt++;
      pv = valid;
    end
  end

  // Called right after a new level is driven on a falling edge: valid must rise on the 7th rising edge.
  task automatic lat(input logic [1:0] exp_code);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("lat_early", 8'(valid), 8'd0);
    end
    @(posedge clk); #1;
    chk("lat_valid", 8'(valid), 8'd1);
    chk("lat_code", 8'(code), 8'(exp_code));
    @(negedge clk);
  endtask

  task automatic consume_release();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    din_n = 4'hF;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int r0, o0, len;
    logic [3:0] pats [4];
    pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
    rst = 1'b1; din_n = 4'hF; ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 8'(valid), 8'd0);
    chk("rst_code", 8'(code), 8'd0);
    chk("rst_key_down", 8'(key_down), 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single press and handshake
    din_n = 4'b1101;
    lat(2'd1);
    repeat (20) @(negedge clk);
    chk("held_valid", 8'(valid), 8'd1);
    chk("held_code", 8'(code), 8'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("ready_clears", 8'(valid), 8'd0);
    r0 = rises;
    repeat (50) @(negedge clk);
    chk("no_second_event", 8'(rises - r0), 8'd0);
    din_n = 4'hF;
    repeat (10) @(negedge clk);

    // reset mid-press with a pending code
    din_n = 4'b0111;
    lat(2'd3);
    rst = 1'b1;
    din_n = 4'b1011;
    #1;
    chk("midrst_valid", 8'(valid), 8'd0);
    chk("midrst_code", 8'(code), 8'd0);
    chk("midrst_key_down", 8'(key_down), 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat(2'd2);
    consume_release();

    // bounce
    r0 = rises;
    for (int i = 0; i < 10; i++) begin
      din_n = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      repeat (2) @(negedge clk);
    end
    chk("bounce_no_event", 8'(rises - r0), 8'd0);
    din_n = 4'b1110;
    lat(2'd0);
    chk("bounce_one_event", 8'(rises - r0), 8'd1);
    consume_release();

    // priority and multi
    din_n = 4'b0011;
    lat(2'd2);
    chk("prio_multi", 8'(multi), 8'd1);
    chk("prio_key_down", 8'(key_down), 8'd1);
    r0 = rises; o0 = ovr_cnt;
    din_n = 4'b0111;
    repeat (10) @(negedge clk);
    chk("held_change_multi", 8'(multi), 8'd0);
    chk("held_change_code", 8'(code), 8'd2);
    chk("held_change_no_ev", 8'(rises - r0 + ovr_cnt - o0), 8'd0);
    consume_release();
    din_n = 4'b0111;
    lat(2'd3);
    consume_release();

    // overrun
    din_n = 4'b1110;
    lat(2'd0);
    din_n = 4'hF;
    repeat (10) @(negedge clk);
    o0 = ovr_cnt;
    din_n = 4'b0111;
    repeat (12) @(negedge clk);
    chk("overrun_one_cycle", 8'(ovr_cnt - o0), 8'd1);
    chk("overrun_code_kept", 8'(code), 8'd0);
    chk("overrun_valid_kept", 8'(valid), 8'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("overrun_consumed", 8'(valid), 8'd0);
    din_n = 4'hF;
    repeat (10) @(negedge clk);
    din_n = 4'b1011;
    lat(2'd2);
    consume_release();

    // back-to-back with ready tied high
    ready = 1'b1;
    r0 = rises; o0 = ovr_cnt;
    for (int k = 0; k < 4; k++) begin
      din_n = pats[k];
      lat(2'(k));
      @(posedge clk); #1;
      chk("b2b_one_cycle", 8'(valid), 8'd0);
      @(negedge clk);
      din_n = 4'hF;
      repeat (10) @(negedge clk);
    end
    chk("b2b_events", 8'(rises - r0), 8'd4);
    chk("b2b_no_overrun", 8'(ovr_cnt - o0), 8'd0);
    ready = 1'b0;

    // random traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      din_n = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      for (int j = 0; j < len; j++) begin
        ready = ($urandom_range(0, 2) == 0);
        @(negedge clk);
      end
    end
    din_n = 4'hF;
    ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onehot_key_encoder.md
Name: onehot_key_encoder

Overview:
- Reverse direction of the 2-to-4 active-low digit/line decoder: takes 4 active-low one-hot lines from board buttons or returned select lines and produces a 2-bit code.
- Synchronises, debounces, priority-encodes and emits one code per press, using a valid/ready handshake toward the consumer (display or control FSM).

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clk edges a new input level must hold before it is accepted; legal range >= 1; board builds override to ~1_000_000.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- din_n  input  4  active-low lines, asynchronous to clk; 0 = line asserted
- code  output  2  encoded index of pressed line
- valid  output  1  code holds an unconsumed press event
- ready  input  1  consumer accepts code when valid && ready at a clk edge
- key_down  output  1  level: debounced input not all-ones
- multi  output  1  level: debounced input has more than one 0
- overrun  output  1  one-cycle pulse: press event dropped

Behaviour:
- Reset (async, rst=1): sync FFs = 4'b1111, stable = 4'b1111, cnt = 0, FSM = IDLE, code = 2'd0, valid = 0, overrun = 0. key_down = 0, multi = 0 (derived from stable).
- Synchroniser:
  - 2-FF chain s1 <= din_n, s2 <= s1. No other logic reads din_n.
- Debounce:
  - If s2 == stable: cnt <= 0.
  - If s2 differs from stable and from its value on the previous edge: cnt restarts at 1.
  - Otherwise cnt increments.
  - stable <= s2 on the edge where s2 has held one identical non-stable value for DEBOUNCE_CYCLES consecutive edges; cnt <= 0 on that edge.
  - cnt saturates and never wraps.
  - Glitches shorter than DEBOUNCE_CYCLES never reach stable.
- Priority encode of stable: lowest-index 0 wins.
  - 1110->0, xx01->1, x011->2, 0111->3.
  - Exact inverse of the decoder for single-hot patterns.
  - all-ones gives no key; encode output is don't-care and not loaded.
- FSM, 2 states:
  - IDLE: stable != 4'b1111 -> HELD and raise a press event (combinational, this cycle). Otherwise stay.
  - HELD: stable == 4'b1111 -> IDLE. Any other change, e.g. 1110->1100 or 1110->1101, is ignored; no new event until full release.
- Output register, per edge:
  - Event && (!valid || ready): code <= encode(stable), valid <= 1.
  - Event && valid && !ready: code/valid unchanged, overrun <= 1 for one cycle; new event lost.
  - No event && valid && ready: valid <= 0; code keeps last value.
  - overrun is 0 on every edge not listed above.
  - code must not change while valid=1 && ready=0.
- Latency: let E0 be the edge at which s1 first captures a new steady level.
  - stable updates at edge E0+1+DEBOUNCE_CYCLES.
  - valid rises at edge E0+2+DEBOUNCE_CYCLES.
  - With default 4: valid high 6 edges after E0.
- Release: key_down falls at the same edge stable returns to 4'b1111; no release event; valid unaffected.
- Reset mid-operation: all state returns to reset values immediately, pending valid discarded. First event after rst deassert requires the full debounce interval.
- multi/key_down: combinational from stable, glitch-free, change only on the edge stable changes.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert rst mid-press with valid=1 -> valid=0, code=0, key_down=0 immediately. After release of rst with din_n held 4'b1011, valid rises exactly 6 edges later with code=2.
- Single press/handshake: din_n 1111->1101, ready=0 -> valid=1 and code=1 after 6 edges, held stable 20 cycles. Pulse ready for 1 edge -> valid=0 next edge; hold key 50 cycles -> no second event.
- Bounce: din_n toggles 1110/1111 every 2 cycles for 20 cycles, then settles at 1110 -> exactly one event, code=0, valid 6 edges after final settle; no events during bounce.
- Priority/multi: din_n = 4'b0011 -> code=2, multi=1, key_down=1. Then change to 0111 while held -> no new event, multi=0. Release then press 0111 -> new event, code=3.
- Overrun: press 1110 (valid=1, ready=0), release, press 0111 -> overrun pulses 1 cycle at second event, code stays 0. Assert ready -> valid=0; next press accepted normally.
- Back-to-back: ready tied 1; press/release 1110, 1101, 1011, 0111 each 10 cycles apart -> codes 0,1,2,3 each valid exactly 1 cycle, overrun never asserted.
